// File: rtl/data_mem_responder.sv
// Data-side memory responder for a small core: word RAM plus a peripheral page
// holding GPIO, a free-running 64-bit cycle counter and the TOHOST halt mailbox.
module data_mem_responder #(
    parameter int DEPTH  = 64,
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memWrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       storeData,
    output logic [31:0]       readData,
    output logic [GPIO_W-1:0] gpioOut,
    output logic              halt,
    output logic [31:0]       haltCode,
    output logic              misalignErr
);

    localparam int AW = $clog2(DEPTH);

    // Peripheral page is the 16-byte window at 0x8000_0000; addr[3:2] picks the register.
    localparam logic [27:0] PERIPH_PAGE = 28'h8000_000;
    localparam logic [1:0]  SEL_GPIO    = 2'd0;
    localparam logic [1:0]  SEL_CNT_LO  = 2'd1;
    localparam logic [1:0]  SEL_CNT_HI  = 2'd2;
    localparam logic [1:0]  SEL_TOHOST  = 2'd3;

    logic [31:0]       r_mem [DEPTH];
    logic [GPIO_W-1:0] r_gpio;
    logic              r_halt;
    logic [31:0]       r_halt_code;
    logic              r_misalign;
    logic [63:0]       r_counter;

    logic          w_aligned;
    logic          w_ram_sel;
    logic          w_periph_sel;
    logic          w_gpio_sel;
    logic          w_cnt_lo_sel;
    logic          w_cnt_hi_sel;
    logic          w_tohost_sel;
    logic [AW-1:0] w_ram_idx;
    logic          w_store_ok;

    // Any nonzero bit above the RAM index makes the address unmapped, so RAM never aliases.
    assign w_aligned    = (addr[1:0] == 2'b00);
    assign w_ram_sel    = (addr[31:AW+2] == '0);
    assign w_periph_sel = (addr[31:4] == PERIPH_PAGE);
    assign w_gpio_sel   = w_periph_sel && (addr[3:2] == SEL_GPIO);
    assign w_cnt_lo_sel = w_periph_sel && (addr[3:2] == SEL_CNT_LO);
    assign w_cnt_hi_sel = w_periph_sel && (addr[3:2] == SEL_CNT_HI);
    assign w_tohost_sel = w_periph_sel && (addr[3:2] == SEL_TOHOST);
    assign w_ram_idx    = addr[AW+1:2];

    // Reset also blocks the RAM write so a store coincident with reset never lands.
    assign w_store_ok = memWrite && w_aligned && !r_halt && !reset;

    always_ff @(posedge clk) begin
        if (w_store_ok && w_ram_sel) begin
            r_mem[w_ram_idx] <= storeData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gpio      <= '0;
            r_halt      <= 1'b0;
            r_halt_code <= '0;
            r_misalign  <= 1'b0;
        end else begin
            if (w_store_ok && w_gpio_sel) begin
                r_gpio <= storeData[GPIO_W-1:0];
            end
            if (w_store_ok && w_tohost_sel) begin
                r_halt      <= 1'b1;
                r_halt_code <= storeData;
            end
            // Misalignment is flagged even while halted.
            if (memWrite && !w_aligned) begin
                r_misalign <= 1'b1;
            end
        end
    end

    // A CNT_LO store takes priority over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter <= '0;
        end else if (w_store_ok && w_cnt_lo_sel) begin
            r_counter <= '0;
        end else if (!r_halt) begin
            r_counter <= r_counter + 64'd1;
        end
    end

    always_comb begin
        readData = '0;
        if (w_ram_sel) begin
            readData = r_mem[w_ram_idx];
        end else if (w_gpio_sel) begin
            readData = 32'(r_gpio);
        end else if (w_cnt_lo_sel) begin
            readData = r_counter[31:0];
        end else if (w_cnt_hi_sel) begin
            readData = r_counter[63:32];
        end else if (w_tohost_sel) begin
            readData = r_halt_code;
        end
    end

    assign gpioOut     = r_gpio;
    assign halt        = r_halt;
    assign haltCode    = r_halt_code;
    assign misalignErr = r_misalign;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: each task drives one scenario and checks
// its own outputs against hand-computed values.
module tb_data_mem_responder;

    localparam logic [31:0] A_GPIO   = 32'h8000_0000;
    localparam logic [31:0] A_CNT_LO = 32'h8000_0004;
    localparam logic [31:0] A_CNT_HI = 32'h8000_0008;
    localparam logic [31:0] A_TOHOST = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [31:0] readData;
    logic [7:0]  gpioOut;
    logic        halt;
    logic [31:0] haltCode;
    logic        misalignErr;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder #(.DEPTH(64), .GPIO_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .memWrite    (memWrite),
        .addr        (addr),
        .storeData   (storeData),
        .readData    (readData),
        .gpioOut     (gpioOut),
        .halt        (halt),
        .haltCode    (haltCode),
        .misalignErr (misalignErr)
    );

    always #5 clk = ~clk;

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; storeData = d; memWrite = 1'b1;
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        $display("store addr=%08h data=%08h", a, d);
    endtask

    task automatic test_reset();
        reset = 1'b1; memWrite = 1'b1; addr = A_GPIO; storeData = 32'hAB;
        repeat (3) @(posedge clk);
        #1;
        addr = A_CNT_LO;
        #1;
        n_checks++; if (gpioOut !== 8'h00) begin n_errors++; $display("FAIL reset_gpio got=%h exp=00", gpioOut); end
        n_checks++; if (halt !== 1'b0) begin n_errors++; $display("FAIL reset_halt got=%b exp=0", halt); end
        n_checks++; if (haltCode !== 32'h0) begin n_errors++; $display("FAIL reset_haltcode got=%h exp=0", haltCode); end
        n_checks++; if (misalignErr !== 1'b0) begin n_errors++; $display("FAIL reset_misalign got=%b exp=0", misalignErr); end
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL reset_cnt got=%h exp=0", readData); end
        @(negedge clk);
        reset = 1'b0; memWrite = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_counter();
        repeat (10) @(posedge clk);
        #1;
        addr = A_CNT_LO;
        #1;
        n_checks++; if (readData !== 32'd10) begin n_errors++; $display("FAIL cnt_after10 got=%0d exp=10", readData); end
        do_store(A_CNT_LO, 32'h1234_5678);
        #1;
        n_checks++; if (readData !== 32'd0) begin n_errors++; $display("FAIL cnt_cleared got=%0d exp=0", readData); end
        @(posedge clk);
        #1;
        n_checks++; if (readData !== 32'd1) begin n_errors++; $display("FAIL cnt_after_clear got=%0d exp=1", readData); end
        $display("test_counter done");
    endtask

    task automatic test_ram();
        do_store(32'h0000_0010, 32'hDEAD_BEEF);
        addr = 32'h0000_0010; #1;
        n_checks++; if (readData !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ram_read got=%h exp=deadbeef", readData); end
        addr = 32'h0000_0013; #1;
        n_checks++; if (readData !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ram_read_unaligned got=%h exp=deadbeef", readData); end
        do_store(32'h0000_0000, 32'hA5A5_0000);
        do_store(32'h0000_00FC, 32'h0BAD_F00D);
        do_store(32'h0000_0100, 32'h1234_5678);
        addr = 32'h0000_0000; #1;
        n_checks++; if (readData !== 32'hA5A5_0000) begin n_errors++; $display("FAIL ram_no_alias got=%h exp=a5a50000", readData); end
        addr = 32'h0000_00FC; #1;
        n_checks++; if (readData !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL ram_top_word got=%h exp=0badf00d", readData); end
        addr = 32'h0000_0100; #1;
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL ram_past_end got=%h exp=0", readData); end
        $display("test_ram done");
    endtask

    task automatic test_back_to_back();
        do_store(32'h0000_0020, 32'h1111_0020);
        do_store(32'h0000_0024, 32'h2222_0024);
        do_store(32'h0000_0028, 32'h3333_0028);
        addr = 32'h0000_0020; #1;
        n_checks++; if (readData !== 32'h1111_0020) begin n_errors++; $display("FAIL b2b_0 got=%h exp=11110020", readData); end
        addr = 32'h0000_0024; #1;
        n_checks++; if (readData !== 32'h2222_0024) begin n_errors++; $display("FAIL b2b_1 got=%h exp=22220024", readData); end
        addr = 32'h0000_0028; #1;
        n_checks++; if (readData !== 32'h3333_0028) begin n_errors++; $display("FAIL b2b_2 got=%h exp=33330028", readData); end
        $display("test_back_to_back done");
    endtask

    task automatic test_gpio();
        do_store(A_GPIO, 32'h0000_01FF);
        addr = A_GPIO; #1;
        n_checks++; if (gpioOut !== 8'hFF) begin n_errors++; $display("FAIL gpio_out got=%h exp=ff", gpioOut); end
        n_checks++; if (readData !== 32'h0000_00FF) begin n_errors++; $display("FAIL gpio_read got=%h exp=000000ff", readData); end
        do_store(A_CNT_HI, 32'hFFFF_FFFF);
        addr = A_CNT_HI; #1;
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL cnt_hi_ignored got=%h exp=0", readData); end
        $display("test_gpio done");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.r_counter = 64'h0000_0000_FFFF_FFFF;
        addr = A_CNT_LO; #1;
        release dut.r_counter;
        @(posedge clk); #1;
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL wrap_lo got=%h exp=0", readData); end
        addr = A_CNT_HI; #1;
        n_checks++; if (readData !== 32'h1) begin n_errors++; $display("FAIL wrap_hi_carry got=%h exp=1", readData); end
        @(negedge clk);
        force dut.r_counter = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_counter;
        @(posedge clk); #1;
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL wrap64_hi got=%h exp=0", readData); end
        addr = A_CNT_LO; #1;
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL wrap64_lo got=%h exp=0", readData); end
        $display("test_wrap done");
    endtask

    task automatic test_misalign_unmapped();
        do_store(32'h8000_0002, 32'h0000_0055);
        n_checks++; if (misalignErr !== 1'b1) begin n_errors++; $display("FAIL misalign_set got=%b exp=1", misalignErr); end
        n_checks++; if (gpioOut !== 8'hFF) begin n_errors++; $display("FAIL misalign_gpio got=%h exp=ff", gpioOut); end
        do_store(32'h4000_0000, 32'h0000_0077);
        addr = 32'h4000_0000; #1;
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL unmapped_read got=%h exp=0", readData); end
        n_checks++; if (halt !== 1'b0) begin n_errors++; $display("FAIL unmapped_halt got=%b exp=0", halt); end
        addr = 32'h0000_0000; #1;
        n_checks++; if (readData !== 32'hA5A5_0000) begin n_errors++; $display("FAIL unmapped_no_alias got=%h exp=a5a50000", readData); end
        $display("test_misalign_unmapped done");
    endtask

    task automatic test_halt();
        do_store(32'h0000_0000, 32'h1111_1111);
        do_store(A_GPIO, 32'h0000_003C);
        do_store(A_CNT_LO, 32'h0);
        do_store(A_TOHOST, 32'h0000_0001);
        n_checks++; if (halt !== 1'b1) begin n_errors++; $display("FAIL halt_set got=%b exp=1", halt); end
        n_checks++; if (haltCode !== 32'h1) begin n_errors++; $display("FAIL halt_code got=%h exp=1", haltCode); end
        do_store(32'h0000_0000, 32'h2222_2222);
        do_store(A_GPIO, 32'h0000_00FF);
        do_store(A_TOHOST, 32'h0000_0005);
        do_store(A_CNT_LO, 32'h0);
        addr = 32'h0000_0000; #1;
        n_checks++; if (readData !== 32'h1111_1111) begin n_errors++; $display("FAIL halt_ram got=%h exp=11111111", readData); end
        n_checks++; if (gpioOut !== 8'h3C) begin n_errors++; $display("FAIL halt_gpio got=%h exp=3c", gpioOut); end
        addr = A_TOHOST; #1;
        n_checks++; if (readData !== 32'h1) begin n_errors++; $display("FAIL halt_tohost got=%h exp=1", readData); end
        addr = A_CNT_LO; #1;
        n_checks++; if (readData !== 32'h1) begin n_errors++; $display("FAIL halt_cnt_frozen got=%h exp=1", readData); end
        $display("test_halt done");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        addr = A_CNT_LO; #1;
        n_checks++; if (halt !== 1'b0) begin n_errors++; $display("FAIL mid_halt got=%b exp=0", halt); end
        n_checks++; if (haltCode !== 32'h0) begin n_errors++; $display("FAIL mid_haltcode got=%h exp=0", haltCode); end
        n_checks++; if (misalignErr !== 1'b0) begin n_errors++; $display("FAIL mid_misalign got=%b exp=0", misalignErr); end
        n_checks++; if (gpioOut !== 8'h00) begin n_errors++; $display("FAIL mid_gpio got=%h exp=00", gpioOut); end
        n_checks++; if (readData !== 32'h0) begin n_errors++; $display("FAIL mid_cnt got=%h exp=0", readData); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (readData !== 32'd3) begin n_errors++; $display("FAIL mid_cnt_restart got=%0d exp=3", readData); end
        addr = 32'h0000_0000; #1;
        n_checks++; if (readData !== 32'h1111_1111) begin n_errors++; $display("FAIL mid_ram_kept got=%h exp=11111111", readData); end
        $display("test_reset_mid_run done");
    endtask

    task automatic test_halt_misalign();
        do_store(A_TOHOST, 32'h0000_0077);
        do_store(32'h8000_000D, 32'h0000_00AA);
        n_checks++; if (misalignErr !== 1'b1) begin n_errors++; $display("FAIL halted_misalign got=%b exp=1", misalignErr); end
        n_checks++; if (haltCode !== 32'h77) begin n_errors++; $display("FAIL halted_code got=%h exp=77", haltCode); end
        $display("test_halt_misalign done");
    endtask

    task automatic test_reset_with_tohost();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_store(32'h0000_0008, 32'hCAFE_F00D);
        @(negedge clk);
        reset = 1'b1; addr = A_TOHOST; storeData = 32'h99; memWrite = 1'b1;
        @(posedge clk); #1;
        memWrite = 1'b0;
        n_checks++; if (halt !== 1'b0) begin n_errors++; $display("FAIL rst_tohost_halt got=%b exp=0", halt); end
        n_checks++; if (haltCode !== 32'h0) begin n_errors++; $display("FAIL rst_tohost_code got=%h exp=0", haltCode); end
        @(negedge clk);
        reset = 1'b0;
        addr = 32'h0000_0008; #1;
        n_checks++; if (readData !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL rst_tohost_ram got=%h exp=cafef00d", readData); end
        $display("test_reset_with_tohost done");
    endtask

    initial begin
        test_reset();
        test_counter();
        test_ram();
        test_back_to_back();
        test_gpio();
        test_wrap();
        test_misalign_unmapped();
        test_halt();
        test_reset_mid_run();
        test_halt_misalign();
        test_reset_with_tohost();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
